// File: rtl/game_flow_controller.sv
// Game flow sequencer with built-in frame-tick timing and collision detection.
module game_flow_controller #(
  parameter int NUM_LEVELS     = 3,
  parameter int NUM_LIVES      = 3,
  parameter int OPEN_FRAMES    = 150,
  parameter int HOLDOFF_FRAMES = 5,
  parameter int LOST_FRAMES    = 60,
  parameter int LEVEL_FRAMES   = 40,
  parameter int WIN_FRAMES     = 40,
  parameter int LEVEL_W        = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  parameter int LIVES_W        = $clog2(NUM_LIVES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               startGame,
  input  logic               restartGame,
  input  logic               ballDrawReq,
  input  logic               batDrawReq,
  input  logic               brickDrawReq,
  input  logic               ballHitGround,
  input  logic               noBricksLeft,
  input  logic               cheat,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  output logic               changeCourse,
  output logic               hit,
  output logic [10:0]        hit_pixelX,
  output logic [10:0]        hit_pixelY,
  output logic               ena_move,
  output logic               new_level,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic               opening_screen,
  output logic               ready_screen,
  output logic               lost_screen,
  output logic               level_screen,
  output logic               win_screen,
  output logic               over_screen,
  output logic               background_only
);

  localparam int CNT_W = 16;

  typedef enum logic [3:0] {
    S_OPENING,
    S_READY,
    S_PLAY,
    S_HIT_BAT,
    S_HIT_BRICK,
    S_HOLDOFF,
    S_LIFE_LOST,
    S_LEVEL_DONE,
    S_GAME_WON,
    S_GAME_OVER
  } state_t;

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [10:0]        hit_x_q, hit_x_d;
  logic [10:0]        hit_y_q, hit_y_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               new_level_q, new_level_d;
  logic               clear_cnt;

  // True on the clock of the frames-th startOfFrame since the state was entered.
  function automatic logic frames_done(input logic [CNT_W-1:0] cnt, input int frames);
    return startOfFrame && (cnt == CNT_W'(frames - 1));
  endfunction

  function automatic logic [LIVES_W-1:0] lose_life(input logic [LIVES_W-1:0] l);
    return (l != '0) ? l - LIVES_W'(1) : l;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OPENING;
      level_q     <= '0;
      lives_q     <= LIVES_W'(NUM_LIVES);
      hit_x_q     <= '0;
      hit_y_q     <= '0;
      frame_cnt_q <= '0;
      new_level_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      lives_q     <= lives_d;
      hit_x_q     <= hit_x_d;
      hit_y_q     <= hit_y_d;
      frame_cnt_q <= frame_cnt_d;
      new_level_q <= new_level_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    lives_d     = lives_q;
    hit_x_d     = hit_x_q;
    hit_y_d     = hit_y_q;
    new_level_d = 1'b0;
    clear_cnt   = 1'b0;

    unique case (state_q)
      S_OPENING: begin
        if (frames_done(frame_cnt_q, OPEN_FRAMES)) begin
          state_d     = S_READY;
          new_level_d = 1'b1;
        end
      end
      S_READY: begin
        if (startGame) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (ballDrawReq && batDrawReq) begin
          state_d = S_HIT_BAT;
          hit_x_d = pixelX;
          hit_y_d = pixelY;
        end else if (ballDrawReq && brickDrawReq) begin
          state_d = S_HIT_BRICK;
          hit_x_d = pixelX;
          hit_y_d = pixelY;
        end else if (ballHitGround) begin
          state_d = S_LIFE_LOST;
          lives_d = lose_life(lives_q);
        end else if (noBricksLeft || cheat) begin
          state_d = S_LEVEL_DONE;
        end
      end
      S_HIT_BAT, S_HIT_BRICK: begin
        state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (ballHitGround) begin
          state_d = S_LIFE_LOST;
          lives_d = lose_life(lives_q);
        end else if (frames_done(frame_cnt_q, HOLDOFF_FRAMES)) begin
          state_d = S_PLAY;
        end
      end
      S_LIFE_LOST: begin
        if (lives_q == '0) begin
          state_d = S_GAME_OVER;
        end else if (frames_done(frame_cnt_q, LOST_FRAMES)) begin
          state_d     = S_READY;
          new_level_d = 1'b1;
        end
      end
      S_LEVEL_DONE: begin
        if (frames_done(frame_cnt_q, LEVEL_FRAMES)) begin
          if (level_q == LEVEL_W'(NUM_LEVELS - 1)) begin
            state_d = S_GAME_WON;
          end else begin
            state_d     = S_READY;
            level_d     = level_q + LEVEL_W'(1);
            new_level_d = 1'b1;
          end
        end
      end
      S_GAME_WON: begin
        if (frames_done(frame_cnt_q, WIN_FRAMES)) begin
          state_d     = S_READY;
          level_d     = '0;
          lives_d     = LIVES_W'(NUM_LIVES);
          new_level_d = 1'b1;
        end
      end
      S_GAME_OVER: begin
        state_d = S_GAME_OVER;
      end
      default: state_d = S_OPENING;
    endcase

    // Restart overrides everything above, including a READY->READY case that must still clear the counter.
    if (restartGame) begin
      state_d     = S_READY;
      level_d     = '0;
      lives_d     = LIVES_W'(NUM_LIVES);
      hit_x_d     = '0;
      hit_y_d     = '0;
      new_level_d = 1'b1;
      clear_cnt   = 1'b1;
    end

    if (clear_cnt || (state_d != state_q)) begin
      frame_cnt_d = '0;
    end else if (startOfFrame) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  always_comb begin
    changeCourse    = 1'b0;
    hit             = 1'b0;
    ena_move        = 1'b0;
    opening_screen  = 1'b0;
    ready_screen    = 1'b0;
    lost_screen     = 1'b0;
    level_screen    = 1'b0;
    win_screen      = 1'b0;
    over_screen     = 1'b0;
    background_only = 1'b0;
    unique case (state_q)
      S_OPENING:    begin opening_screen = 1'b1; background_only = 1'b1; end
      S_READY:      ready_screen = 1'b1;
      S_PLAY:       ena_move = 1'b1;
      S_HIT_BAT:    begin ena_move = 1'b1; changeCourse = 1'b1; end
      S_HIT_BRICK:  begin ena_move = 1'b1; changeCourse = 1'b1; hit = 1'b1; end
      S_HOLDOFF:    ena_move = 1'b1;
      S_LIFE_LOST:  begin lost_screen  = 1'b1; background_only = 1'b1; end
      S_LEVEL_DONE: begin level_screen = 1'b1; background_only = 1'b1; end
      S_GAME_WON:   begin win_screen   = 1'b1; background_only = 1'b1; end
      S_GAME_OVER:  begin over_screen  = 1'b1; background_only = 1'b1; end
      default:      begin opening_screen = 1'b1; background_only = 1'b1; end
    endcase
  end

  assign hit_pixelX = hit_x_q;
  assign hit_pixelY = hit_y_q;
  assign new_level  = new_level_q;
  assign level      = level_q;
  assign lives      = lives_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed scenarios followed by random stimulus,
// every cycle compared against a countdown-based reference model.
module tb_game_flow_controller;

  localparam int P_LEVELS = 2;
  localparam int P_LIVES  = 2;
  localparam int P_OPEN   = 3;
  localparam int P_HOLD   = 2;
  localparam int P_LOST   = 2;
  localparam int P_LEVEL  = 2;
  localparam int P_WIN    = 2;
  localparam int LEVEL_W  = 1;
  localparam int LIVES_W  = 2;

  logic clk = 1'b0;
  logic reset, startOfFrame, startGame, restartGame;
  logic ballDrawReq, batDrawReq, brickDrawReq, ballHitGround, noBricksLeft, cheat;
  logic [10:0] pixelX, pixelY;
  logic changeCourse, hit, ena_move, new_level;
  logic [10:0] hit_pixelX, hit_pixelY;
  logic [LEVEL_W-1:0] level;
  logic [LIVES_W-1:0] lives;
  logic opening_screen, ready_screen, lost_screen, level_screen, win_screen, over_screen;
  logic background_only;

  int n_tests = 0;
  int n_fail  = 0;

  game_flow_controller #(
    .NUM_LEVELS    (P_LEVELS),
    .NUM_LIVES     (P_LIVES),
    .OPEN_FRAMES   (P_OPEN),
    .HOLDOFF_FRAMES(P_HOLD),
    .LOST_FRAMES   (P_LOST),
    .LEVEL_FRAMES  (P_LEVEL),
    .WIN_FRAMES    (P_WIN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .startGame      (startGame),
    .restartGame    (restartGame),
    .ballDrawReq    (ballDrawReq),
    .batDrawReq     (batDrawReq),
    .brickDrawReq   (brickDrawReq),
    .ballHitGround  (ballHitGround),
    .noBricksLeft   (noBricksLeft),
    .cheat          (cheat),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .changeCourse   (changeCourse),
    .hit            (hit),
    .hit_pixelX     (hit_pixelX),
    .hit_pixelY     (hit_pixelY),
    .ena_move       (ena_move),
    .new_level      (new_level),
    .level          (level),
    .lives          (lives),
    .opening_screen (opening_screen),
    .ready_screen   (ready_screen),
    .lost_screen    (lost_screen),
    .level_screen   (level_screen),
    .win_screen     (win_screen),
    .over_screen    (over_screen),
    .background_only(background_only)
  );

  always #5 clk = ~clk;

  // Reference model: game phase plus number of frames still to wait in it.
  localparam int M_OPEN = 0, M_READY = 1, M_PLAY = 2, M_BAT = 3, M_BRICK = 4,
                 M_HOLD = 5, M_LOST = 6, M_LVL = 7, M_WON = 8, M_OVER = 9;
  int m_mode, m_wait, m_level, m_lives, m_hx, m_hy;
  bit m_newlvl;

  task automatic enter(input int mode);
    m_mode = mode;
    case (mode)
      M_OPEN:  m_wait = P_OPEN;
      M_HOLD:  m_wait = P_HOLD;
      M_LOST:  m_wait = P_LOST;
      M_LVL:   m_wait = P_LEVEL;
      M_WON:   m_wait = P_WIN;
      default: m_wait = 0;
    endcase
  endtask

  // Returns 1 when this startOfFrame is the last one the phase waits for.
  function automatic bit tick();
    if (!startOfFrame) return 1'b0;
    m_wait = m_wait - 1;
    return (m_wait == 0);
  endfunction

  task automatic lose_life();
    if (m_lives > 0) m_lives = m_lives - 1;
    enter(M_LOST);
  endtask

  task automatic model_step();
    m_newlvl = 1'b0;
    if (reset) begin
      enter(M_OPEN);
      m_level = 0; m_lives = P_LIVES; m_hx = 0; m_hy = 0;
      return;
    end
    if (restartGame) begin
      enter(M_READY);
      m_level = 0; m_lives = P_LIVES; m_hx = 0; m_hy = 0; m_newlvl = 1'b1;
      return;
    end
    case (m_mode)
      M_OPEN:  if (tick()) begin enter(M_READY); m_newlvl = 1'b1; end
      M_READY: if (startGame) enter(M_PLAY);
      M_PLAY: begin
        if (ballDrawReq && batDrawReq) begin
          enter(M_BAT); m_hx = int'(pixelX); m_hy = int'(pixelY);
        end else if (ballDrawReq && brickDrawReq) begin
          enter(M_BRICK); m_hx = int'(pixelX); m_hy = int'(pixelY);
        end else if (ballHitGround) lose_life();
        else if (noBricksLeft || cheat) enter(M_LVL);
      end
      M_BAT, M_BRICK: enter(M_HOLD);
      M_HOLD: begin
        if (ballHitGround) lose_life();
        else if (tick()) enter(M_PLAY);
      end
      M_LOST: begin
        if (m_lives == 0) enter(M_OVER);
        else if (tick()) begin enter(M_READY); m_newlvl = 1'b1; end
      end
      M_LVL: if (tick()) begin
        if (m_level == P_LEVELS - 1) enter(M_WON);
        else begin m_level++; enter(M_READY); m_newlvl = 1'b1; end
      end
      M_WON: if (tick()) begin
        enter(M_READY); m_level = 0; m_lives = P_LIVES; m_newlvl = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    logic [5:0] exp_scr;
    bit moving;
    exp_scr = '0;
    case (m_mode)
      M_OPEN:  exp_scr = 6'b100000;
      M_READY: exp_scr = 6'b010000;
      M_LOST:  exp_scr = 6'b001000;
      M_LVL:   exp_scr = 6'b000100;
      M_WON:   exp_scr = 6'b000010;
      M_OVER:  exp_scr = 6'b000001;
      default: exp_scr = 6'b000000;
    endcase
    moving = (m_mode == M_PLAY) || (m_mode == M_BAT) || (m_mode == M_BRICK) || (m_mode == M_HOLD);
    check("screens", 32'({opening_screen, ready_screen, lost_screen, level_screen,
                          win_screen, over_screen}), 32'(exp_scr));
    check("ena_move", 32'(ena_move), 32'(moving));
    check("bg_only", 32'(background_only), 32'(!moving && m_mode != M_READY));
    check("chg_course", 32'(changeCourse), 32'(m_mode == M_BAT || m_mode == M_BRICK));
    check("hit", 32'(hit), 32'(m_mode == M_BRICK));
    check("new_level", 32'(new_level), 32'(m_newlvl));
    check("level", 32'(level), 32'(m_level));
    check("lives", 32'(lives), 32'(m_lives));
    check("hit_x", 32'(hit_pixelX), 32'(m_hx));
    check("hit_y", 32'(hit_pixelY), 32'(m_hy));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
    end
  endtask

  task automatic idle();
    reset = 0; startOfFrame = 0; startGame = 0; restartGame = 0;
    ballDrawReq = 0; batDrawReq = 0; brickDrawReq = 0; ballHitGround = 0;
    noBricksLeft = 0; cheat = 0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(1); startOfFrame = 1; step(1); startOfFrame = 0;
    end
  endtask

  initial begin
    idle(); pixelX = '0; pixelY = '0;
    reset = 1; step(2); reset = 0;
    frames(P_OPEN); step(2);
    // Triple collision at (100,200): bat wins, then brick hits ignored during holdoff.
    startGame = 1; step(1); startGame = 0;
    pixelX = 11'd100; pixelY = 11'd200;
    ballDrawReq = 1; batDrawReq = 1; brickDrawReq = 1; step(1);
    batDrawReq = 0; pixelX = 11'd7; pixelY = 11'd9;
    frames(P_HOLD); step(2); idle();
    // Lose both lives, then restart.
    frames(P_HOLD); ballHitGround = 1; step(1); ballHitGround = 0;
    frames(P_LOST); startGame = 1; step(1); startGame = 0;
    ballHitGround = 1; step(1); ballHitGround = 0; step(4);
    restartGame = 1; step(1); restartGame = 0;
    // Cheat through both levels to the win screen.
    startGame = 1; step(1); startGame = 0; cheat = 1; step(1); cheat = 0;
    frames(P_LEVEL); startGame = 1; step(1); startGame = 0;
    cheat = 1; step(1); cheat = 0; frames(P_WIN); step(1);
    // Restart beats a simultaneous bat collision; reset mid-holdoff.
    startGame = 1; step(1); startGame = 0;
    ballDrawReq = 1; batDrawReq = 1; restartGame = 1; step(1); idle();
    startGame = 1; step(1); startGame = 0;
    ballDrawReq = 1; batDrawReq = 1; step(2); idle();
    reset = 1; step(1); reset = 0; step(2);

    for (int c = 0; c < 6000; c++) begin
      reset         = ($urandom_range(999) == 0);
      restartGame   = ($urandom_range(299) == 0);
      startOfFrame  = ($urandom_range(3) == 0);
      startGame     = ($urandom_range(7) == 0);
      ballDrawReq   = ($urandom_range(2) == 0);
      batDrawReq    = ($urandom_range(5) == 0);
      brickDrawReq  = ($urandom_range(5) == 0);
      ballHitGround = ($urandom_range(39) == 0);
      noBricksLeft  = ($urandom_range(99) == 0);
      cheat         = ($urandom_range(79) == 0);
      pixelX        = 11'($urandom);
      pixelY        = 11'($urandom);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
Parametrised successor to the single-level game/collision state machine. Sequences opening screen, ready, play, collision handling, life loss, level advance, game won and game over, with built-in frame-tick counters replacing the external counter handshake. Sits between the object drawers (draw requests) and the movement/score/screen-mux logic; one instance per game.

Parameters:
NUM_LEVELS, 3, number of levels; levels indexed 0..NUM_LEVELS-1
NUM_LIVES, 3, lives at game/restart start (>=1)
OPEN_FRAMES, 150, frames the opening screen is shown
HOLDOFF_FRAMES, 5, frames after a collision during which new collisions are ignored
LOST_FRAMES, 60, frames the life-lost screen is shown
LEVEL_FRAMES, 40, frames the level-complete screen is shown
WIN_FRAMES, 40, frames the game-won screen is shown
LEVEL_W, $clog2(NUM_LEVELS) (min 1), level output width
LIVES_W, $clog2(NUM_LIVES+1), lives output width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-clock pulse per video frame
startGame  in  1  level start request (READY only)
restartGame  in  1  full restart request
ballDrawReq  in  1  ball drawing current pixel
batDrawReq  in  1  bat drawing current pixel
brickDrawReq  in  1  a brick drawing current pixel
ballHitGround  in  1  ball reached bottom
noBricksLeft  in  1  all bricks of current level cleared
cheat  in  1  force level complete (demo)
pixelX  in  11  current pixel X
pixelY  in  11  current pixel Y
changeCourse  out  1  one-clock pulse: ball reverses
hit  out  1  one-clock pulse: brick hit
hit_pixelX  out  11  X of last collision
hit_pixelY  out  11  Y of last collision
ena_move  out  1  objects may move
new_level  out  1  one-clock pulse: reload bricks/positions for current level
level  out  LEVEL_W  current level index
lives  out  LIVES_W  lives remaining
opening_screen, ready_screen, lost_screen, level_screen, win_screen, over_screen  out  1 each  screen selects
background_only  out  1  suppress game objects

Behaviour:
- Single clock; reset synchronous active-high (sampled on posedge clk, overrides all inputs).
- Reset values: state=OPENING, level=0, lives=NUM_LIVES, hit_pixelX/Y=0, frame counter=0, all pulses 0; outputs then decode from OPENING (opening_screen=1, background_only=1, ena_move=0).
- States: OPENING, READY, PLAY, HIT_BAT, HIT_BRICK, HOLDOFF, LIFE_LOST, LEVEL_DONE, GAME_WON, GAME_OVER.
- Frame counter: cleared on every state change; increments on startOfFrame. Timed state with N frames exits on the clock of the N-th startOfFrame since entry (counter==N-1 and startOfFrame).
- OPENING: after OPEN_FRAMES -> READY with new_level pulse.
- READY: ready_screen=1, ena_move=0; startGame -> PLAY.
- PLAY: ena_move=1. Priority, same cycle: ballDrawReq&batDrawReq -> HIT_BAT; else ballDrawReq&brickDrawReq -> HIT_BRICK; else ballHitGround -> LIFE_LOST; else noBricksLeft|cheat -> LEVEL_DONE. On either collision, hit_pixelX/Y latch pixelX/Y in that cycle; otherwise they hold.
- HIT_BAT: changeCourse=1 for one clock -> HOLDOFF. HIT_BRICK: changeCourse=1, hit=1 for one clock -> HOLDOFF.
- HOLDOFF: ena_move=1, draw-request collisions ignored; ballHitGround -> LIFE_LOST immediately; else after HOLDOFF_FRAMES -> PLAY.
- LIFE_LOST: lives decrements by 1 on entry. lost_screen=1, background_only=1, ena_move=0. If lives now 0 -> GAME_OVER next cycle; else after LOST_FRAMES -> READY with new_level pulse (level unchanged).
- LEVEL_DONE: level_screen=1, background_only=1, ena_move=0. After LEVEL_FRAMES: if level==NUM_LEVELS-1 -> GAME_WON; else level+1, new_level pulse, -> READY. Lives kept.
- GAME_WON: win_screen=1, background_only=1, ena_move=0; after WIN_FRAMES -> READY with level=0, lives=NUM_LIVES, new_level pulse.
- GAME_OVER: over_screen=1, background_only=1, ena_move=0; waits for restartGame.
- restartGame (not under reset), any state: next state READY, level=0, lives=NUM_LIVES, hit_pixelX/Y=0, counter=0, new_level pulse; takes priority over all transitions in the same cycle.
- lives never underflows; level never exceeds NUM_LEVELS-1. Exactly one screen select high except in PLAY/HIT_*/HOLDOFF (all low).

Test Plan:
Params OPEN=3, HOLDOFF=2, LOST=2, LEVEL=2, WIN=2, NUM_LEVELS=2, NUM_LIVES=2; reset then 3 startOfFrame pulses -> opening_screen high until 3rd pulse, then ready_screen=1, new_level pulsed once, level=0, lives=2.
In PLAY, assert ballDrawReq, batDrawReq, brickDrawReq together at pixel (100,200) -> changeCourse 1 clock, hit=0, hit_pixel=(100,200); repeated ballDrawReq&brickDrawReq during next 2 frames -> no pulses; after 2nd frame, brick collision -> hit=1 one clock.
ballHitGround twice (back to PLAY via startGame between) -> lives 2->1, ready_screen after 2 frames, then lives 0, over_screen=1 held until restartGame -> READY, lives=2, level=0.
cheat in PLAY on level 0 -> level_screen 2 frames, level=1, new_level pulse; cheat again -> win_screen 2 frames, then READY, level=0, lives=2.
restartGame asserted in same cycle as ballDrawReq&batDrawReq in PLAY -> READY, no changeCourse; reset asserted mid-HOLDOFF -> OPENING, all outputs at reset values next clock.
